uart_rx_fifo: RTL and testbench

- Receive-side byte buffer between the UART receiver output (DataOut/DataOutValid/DataOutReady) and the memory-mapped IO load path.
- Always accepts bytes from the UART, so the serial line is never back-pressured.
- Presents bytes first-word-fall-through to the CPU-side consumer, which pops one byte per IO data-register load.
- Bytes arriving while the buffer is full are dropped and flagged.

---
 rtl/uart_fifo_pkg.sv | 18 +
 rtl/byte_fifo_core.sv | 57 +++++
 rtl/uart_rx_fifo.sv | 89 ++++++++
 tb/tb_uart_rx_fifo.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_pkg.sv
// Shared constants and width helpers for the UART receive FIFO and the
// memory-map status register that reports its occupancy.
package uart_fifo_pkg;

  localparam int DEFAULT_DEPTH  = 8;
  localparam int DEFAULT_DATA_W = 8;

  // Pointer width; a depth of 1 would otherwise give a zero-width pointer.
  function automatic int ptr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  // Occupancy needs one extra bit to represent the full value DEPTH.
  function automatic int count_w(input int depth);
    return ptr_w(depth) + 1;
  endfunction

endpackage

// File: rtl/byte_fifo_core.sv
// Storage array, read/write pointers and occupancy count for a power-of-two
// deep FIFO. The caller guarantees push is only asserted when legal.
module byte_fifo_core
  import uart_fifo_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int DATA_W = DEFAULT_DATA_W,
  localparam int PW    = ptr_w(DEPTH),
  localparam int CW    = count_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Storage is deliberately left unreset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: never back-pressures the line, drops and flags bytes
// when full, presents bytes FWFT to the CPU. UART_RX_FIFO_HWM_EN adds hwm.
module uart_rx_fifo
  import uart_fifo_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int DATA_W = DEFAULT_DATA_W,
  localparam int CW    = count_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] uart_data,
  input  logic              uart_valid,
  output logic              uart_ready,
  output logic [DATA_W-1:0] cpu_data,
  output logic              cpu_valid,
  input  logic              cpu_pop,
  output logic [CW-1:0]     count,
  output logic              overflow,
  input  logic              overflow_clr,
  output logic [CW-1:0]     hwm
);

  logic              push;
  logic              pop_eff;
  logic              drop;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] head;

  assign uart_ready = rst;
  assign cpu_valid  = !empty;
  assign pop_eff    = cpu_pop && cpu_valid;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push       = uart_valid && uart_ready && (!full || pop_eff);
  assign drop       = uart_valid && uart_ready && full && !pop_eff;
  assign cpu_data   = empty ? '0 : head;

  byte_fifo_core #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop_eff),
    .wr_data (uart_data),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_HWM_EN
  logic [CW-1:0] next_count;

  always_comb begin
    next_count = count;
    if (push && !pop_eff) begin
      next_count = count + CW'(1);
    end else if (pop_eff && !push) begin
      next_count = count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hwm <= '0;
    end else if (overflow_clr) begin
      hwm <= next_count;
    end else if (next_count > hwm) begin
      hwm <= next_count;
    end
  end
`else
  assign hwm = '0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DEPTH=8): a vector table for single-cycle
// behaviour plus hand-written sequences for wrap, overflow and reset cases.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] uart_data = 8'h00;
  logic       uart_valid = 1'b0;
  logic       uart_ready;
  logic [7:0] cpu_data;
  logic       cpu_valid;
  logic       cpu_pop = 1'b0;
  logic [3:0] count;
  logic       overflow;
  logic       overflow_clr = 1'b0;
  logic [3:0] hwm;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_rx_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .uart_data    (uart_data),
    .uart_valid   (uart_valid),
    .uart_ready   (uart_ready),
    .cpu_data     (cpu_data),
    .cpu_valid    (cpu_valid),
    .cpu_pop      (cpu_pop),
    .count        (count),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .hwm          (hwm)
  );

  typedef struct {
    logic       r;
    logic       v;
    logic [7:0] d;
    logic       p;
    logic       c;
    logic       e_valid;
    logic [7:0] e_data;
    logic [3:0] e_count;
    logic       e_ovf;
    logic [3:0] e_hwm;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] hwm_exp(input logic [3:0] v);
`ifdef UART_RX_FIFO_HWM_EN
    return v;
`else
    return 4'd0;
`endif
  endfunction

  task automatic cyc(input logic r, input logic v, input logic [7:0] d,
                     input logic p, input logic c);
    @(negedge clk);
    rst = r; uart_valid = v; uart_data = d; cpu_pop = p; overflow_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    cyc(1'b1, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Head is checked before the popping edge: FWFT data must already be there.
  task automatic pop_chk(input string name, input logic [7:0] exp);
    @(negedge clk);
    rst = 1'b1; uart_valid = 1'b0; uart_data = 8'h00; cpu_pop = 1'b1; overflow_clr = 1'b0;
    #1;
    chk(name, {31'd0, cpu_valid}, 32'd1);
    chk(name, {24'd0, cpu_data}, {24'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string name, input logic e_valid, input logic [7:0] e_data,
                           input logic [3:0] e_count, input logic e_ovf);
    chk({name, ".valid"}, {31'd0, cpu_valid}, {31'd0, e_valid});
    chk({name, ".data"},  {24'd0, cpu_data},  {24'd0, e_data});
    chk({name, ".count"}, {28'd0, count},     {28'd0, e_count});
    chk({name, ".ovf"},   {31'd0, overflow},  {31'd0, e_ovf});
  endtask

  initial begin
    //            r    v    d      p    c    valid data   cnt  ovf  hwm
    vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 4'd0};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 4'd0};
    vecs[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 4'd0};
    vecs[3]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 4'd1, 1'b0, 4'd1};
    vecs[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 4'd1, 1'b0, 4'd1};
    vecs[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 4'd1};
    vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 4'd1};
    vecs[7]  = '{1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 4'd1, 1'b0, 4'd1};
    vecs[8]  = '{1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A, 4'd1, 1'b0, 4'd1};
    vecs[9]  = '{1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 8'h5A, 4'd2, 1'b0, 4'd2};
    vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h77, 4'd1, 1'b0, 4'd2};
    vecs[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 4'd2};

    for (int i = 0; i < 12; i++) begin
      cyc(vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].p, vecs[i].c);
      chk_state($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data,
                vecs[i].e_count, vecs[i].e_ovf);
      chk($sformatf("vec%0d.ready", i), {31'd0, uart_ready}, {31'd0, vecs[i].r});
      chk($sformatf("vec%0d.hwm", i), {28'd0, hwm}, {28'd0, hwm_exp(vecs[i].e_hwm)});
    end

    // Order and pointer wrap
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    chk_state("wrap.fill", 1'b1, 8'h01, 4'd8, 1'b0);
    for (int i = 1; i <= 5; i++) pop_chk("wrap.pop_a", 8'(i));
    chk("wrap.mid_count", {28'd0, count}, 32'd3);
    for (int i = 9; i <= 13; i++) push_byte(8'(i));
    chk_state("wrap.refill", 1'b1, 8'h06, 4'd8, 1'b0);
    for (int i = 6; i <= 13; i++) pop_chk("wrap.pop_b", 8'(i));
    chk_state("wrap.end", 1'b0, 8'h00, 4'd0, 1'b0);

    // Overflow drop
    for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i));
    push_byte(8'hFF);
    chk_state("ovf.drop", 1'b1, 8'h10, 4'd8, 1'b1);
    for (int i = 0; i < 8; i++) pop_chk("ovf.pop", 8'h10 + 8'(i));
    chk_state("ovf.drained", 1'b0, 8'h00, 4'd0, 1'b1);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf.clr", {31'd0, overflow}, 32'd0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 8; i++) push_byte(8'h20 + 8'(i));
    cyc(1'b1, 1'b1, 8'h28, 1'b1, 1'b0);
    chk_state("fullpp", 1'b1, 8'h21, 4'd8, 1'b0);
    for (int i = 1; i <= 8; i++) pop_chk("fullpp.pop", 8'h20 + 8'(i));
    chk("fullpp.empty", {28'd0, count}, 32'd0);

    // Drop and clear in the same cycle: set wins
    for (int i = 0; i < 8; i++) push_byte(8'h30 + 8'(i));
    cyc(1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
    chk_state("dropclr", 1'b1, 8'h30, 4'd8, 1'b1);

    // Reset while full and flagged
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk_state("rst.full", 1'b0, 8'h00, 4'd0, 1'b0);
    chk("rst.full.hwm", {28'd0, hwm}, 32'd0);

    // Reset mid-stream with a push presented during reset
    idle();
    for (int i = 0; i < 3; i++) push_byte(8'h40 + 8'(i));
    chk("mid.count", {28'd0, count}, 32'd3);
    cyc(1'b0, 1'b1, 8'h99, 1'b1, 1'b0);
    chk_state("mid.rst", 1'b0, 8'h00, 4'd0, 1'b0);
    chk("mid.ready", {31'd0, uart_ready}, 32'd0);
    idle();
    chk_state("mid.after", 1'b0, 8'h00, 4'd0, 1'b0);
    chk("mid.hwm", {28'd0, hwm}, 32'd0);

    // High-water mark
    for (int i = 0; i < 6; i++) push_byte(8'h50 + 8'(i));
    chk("hwm.six", {28'd0, hwm}, {28'd0, hwm_exp(4'd6)});
    for (int i = 0; i < 6; i++) pop_chk("hwm.pop", 8'h50 + 8'(i));
    chk("hwm.kept", {28'd0, hwm}, {28'd0, hwm_exp(4'd6)});
    chk("hwm.count", {28'd0, count}, 32'd0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("hwm.clr", {28'd0, hwm}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
